// File: rtl/mem_requester.sv
// mem_requester: initiator-side client of the memory controller request interface.
// Issues one-cycle wr_en/rd_en pulses for accepted commands and tracks in-flight
// requests in a small tag table where the tag is the request address. Returns are
// matched against the table, forwarded as response pulses, and mismatches are flagged.
// Optional feature: define MEM_REQUESTER_TIMEOUT_EN to age entries and drop any that
// stay outstanding for TIMEOUT cycles, reporting them through err_timeout/err_tag.
module mem_requester #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic [15:0] i_cmd_address,
    input  logic [15:0] i_cmd_data,
    output logic        o_wr_en,
    output logic [15:0] o_wr_address,
    output logic [15:0] o_wr_data,
    output logic        o_rd_en,
    output logic [15:0] o_rd_address,
    input  logic        i_wr_ret_ack,
    input  logic [15:0] i_wr_ret_address,
    input  logic        i_rd_ret_ack,
    input  logic [15:0] i_rd_ret_address,
    input  logic [15:0] i_rd_ret_data,
    output logic        o_rd_resp_valid,
    output logic [15:0] o_rd_resp_address,
    output logic [15:0] o_rd_resp_data,
    output logic        o_wr_resp_valid,
    output logic [15:0] o_wr_resp_address,
    output logic [3:0]  o_outstanding,
    output logic        o_err_unexpected,
    output logic        o_err_timeout,
    output logic [15:0] o_err_tag
);

    localparam int N = MAX_OUTSTANDING;

    logic [N-1:0] r_valid;
    logic [N-1:0] r_isWrite;
    logic [15:0]  r_addr [N];

    logic         w_full;
    logic         w_conflict;
    logic         w_accept;
    logic         w_rdUnexp;
    logic         w_wrUnexp;
    logic [3:0]   w_count;
    logic [N-1:0] w_allocOh;
    logic [N-1:0] w_rdHitOh;
    logic [N-1:0] w_wrHitOh;
    logic [N-1:0] w_timeoutOh;
    logic [N-1:0] w_freeOh;

    logic         r_wrEn;
    logic         r_rdEn;
    logic [15:0]  r_wrAddress;
    logic [15:0]  r_wrData;
    logic [15:0]  r_rdAddress;
    logic         r_rdRespValid;
    logic [15:0]  r_rdRespAddress;
    logic [15:0]  r_rdRespData;
    logic         r_wrRespValid;
    logic [15:0]  r_wrRespAddress;
    logic         r_errUnexpected;

    // Table lookups against registered state: command conflict, return hits, occupancy
    always_comb begin
        w_conflict = 1'b0;
        w_rdHitOh  = '0;
        w_wrHitOh  = '0;
        w_count    = '0;
        for (int i = 0; i < N; i++) begin
            if (r_valid[i]) begin
                if (r_addr[i] == i_cmd_address) begin
                    w_conflict = 1'b1;
                end
                if (i_rd_ret_ack && !r_isWrite[i] && (r_addr[i] == i_rd_ret_address)) begin
                    w_rdHitOh[i] = 1'b1;
                end
                if (i_wr_ret_ack && r_isWrite[i] && (r_addr[i] == i_wr_ret_address)) begin
                    w_wrHitOh[i] = 1'b1;
                end
                w_count = w_count + 4'd1;
            end
        end
    end

    // Lowest clear bit of the valid vector is the slot a new command lands in
    assign w_allocOh   = ~r_valid & (r_valid + N'(1));
    assign w_full      = &r_valid;
    assign o_cmd_ready = !w_full && !w_conflict;
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_rdUnexp   = i_rd_ret_ack && !(|w_rdHitOh);
    assign w_wrUnexp   = i_wr_ret_ack && !(|w_wrHitOh);
    assign w_freeOh    = w_rdHitOh | w_wrHitOh | w_timeoutOh;

`ifdef MEM_REQUESTER_TIMEOUT_EN
    localparam int AGEW = $clog2(TIMEOUT + 1);

    logic [AGEW-1:0] r_age [N];
    logic            w_anyTimeout;
    logic [15:0]     w_timeoutTag;
    logic            r_errTimeout;
    logic [15:0]     r_errTag;

    // Entries at the age limit expire unless their return arrives on the same edge
    always_comb begin
        w_timeoutOh  = '0;
        w_anyTimeout = 1'b0;
        w_timeoutTag = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_valid[i] && (r_age[i] == AGEW'(TIMEOUT)) && !w_rdHitOh[i] && !w_wrHitOh[i]) begin
                w_timeoutOh[i] = 1'b1;
                w_anyTimeout   = 1'b1;
                w_timeoutTag   = r_addr[i];
            end
        end
    end

    // Per-entry age counters, cleared on allocation and saturating at the limit
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_accept && w_allocOh[i]) begin
                    r_age[i] <= '0;
                end else if (r_valid[i] && (r_age[i] != AGEW'(TIMEOUT))) begin
                    r_age[i] <= r_age[i] + 1'b1;
                end
            end
        end
    end

    // Sticky timeout flag; the tag keeps the first address that expired
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_errTimeout <= 1'b0;
            r_errTag     <= '0;
        end else if (w_anyTimeout) begin
            r_errTimeout <= 1'b1;
            if (!r_errTimeout) begin
                r_errTag <= w_timeoutTag;
            end
        end
    end

    assign o_err_timeout = r_errTimeout;
    assign o_err_tag     = r_errTag;
`else
    assign w_timeoutOh   = '0;
    assign o_err_timeout = 1'b0;
    assign o_err_tag     = '0;
`endif

    // Tag table: allocate into the free slot on accept, release on return or expiry
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid   <= '0;
            r_isWrite <= '0;
            for (int i = 0; i < N; i++) begin
                r_addr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_accept && w_allocOh[i]) begin
                    r_valid[i]   <= 1'b1;
                    r_isWrite[i] <= i_cmd_write;
                    r_addr[i]    <= i_cmd_address;
                end else if (w_freeOh[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Request pulses toward the controller; fields hold their last value when idle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wrEn      <= 1'b0;
            r_rdEn      <= 1'b0;
            r_wrAddress <= '0;
            r_wrData    <= '0;
            r_rdAddress <= '0;
        end else begin
            r_wrEn <= w_accept && i_cmd_write;
            r_rdEn <= w_accept && !i_cmd_write;
            if (w_accept && i_cmd_write) begin
                r_wrAddress <= i_cmd_address;
                r_wrData    <= i_cmd_data;
            end
            if (w_accept && !i_cmd_write) begin
                r_rdAddress <= i_cmd_address;
            end
        end
    end

    // Completion pulses to the client and the sticky unexpected-return flag
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_rdRespValid   <= 1'b0;
            r_rdRespAddress <= '0;
            r_rdRespData    <= '0;
            r_wrRespValid   <= 1'b0;
            r_wrRespAddress <= '0;
            r_errUnexpected <= 1'b0;
        end else begin
            r_rdRespValid <= |w_rdHitOh;
            r_wrRespValid <= |w_wrHitOh;
            if (|w_rdHitOh) begin
                r_rdRespAddress <= i_rd_ret_address;
                r_rdRespData    <= i_rd_ret_data;
            end
            if (|w_wrHitOh) begin
                r_wrRespAddress <= i_wr_ret_address;
            end
            if (w_rdUnexp || w_wrUnexp) begin
                r_errUnexpected <= 1'b1;
            end
        end
    end

    assign o_wr_en           = r_wrEn;
    assign o_rd_en           = r_rdEn;
    assign o_wr_address      = r_wrAddress;
    assign o_wr_data         = r_wrData;
    assign o_rd_address      = r_rdAddress;
    assign o_rd_resp_valid   = r_rdRespValid;
    assign o_rd_resp_address = r_rdRespAddress;
    assign o_rd_resp_data    = r_rdRespData;
    assign o_wr_resp_valid   = r_wrRespValid;
    assign o_wr_resp_address = r_wrRespAddress;
    assign o_outstanding     = w_count;
    assign o_err_unexpected  = r_errUnexpected;

endmodule

// File: tb/tb_mem_requester.sv
// Testbench for mem_requester: directed scenarios with constant expectations plus a
// randomized run checked against a queue-based model of the outstanding request set.
// The expiry scenario is built only when MEM_REQUESTER_TIMEOUT_EN is defined.
module tb_mem_requester;

    localparam int MAXO = 4;
    localparam int TO   = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic        cmdWrite;
    logic [15:0] cmdAddress;
    logic [15:0] cmdData;
    logic        wrEn;
    logic [15:0] wrAddress;
    logic [15:0] wrData;
    logic        rdEn;
    logic [15:0] rdAddress;
    logic        wrRetAck;
    logic [15:0] wrRetAddress;
    logic        rdRetAck;
    logic [15:0] rdRetAddress;
    logic [15:0] rdRetData;
    logic        rdRespValid;
    logic [15:0] rdRespAddress;
    logic [15:0] rdRespData;
    logic        wrRespValid;
    logic [15:0] wrRespAddress;
    logic [3:0]  outstanding;
    logic        errUnexpected;
    logic        errTimeout;
    logic [15:0] errTag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] addr;
        logic        isWrite;
        int          age;
    } ent_t;

    ent_t mdl[$];

    logic        expReady;
    logic        expRdEn;
    logic        expWrEn;
    logic [15:0] expRdAddr;
    logic [15:0] expWrAddr;
    logic [15:0] expWrData;
    logic        expRdResp;
    logic [15:0] expRdRespAddr;
    logic [15:0] expRdRespData;
    logic        expWrResp;
    logic [15:0] expWrRespAddr;
    logic [3:0]  expOut;
    logic        expErrUnexp;
    logic        expErrTimeout;
    logic [15:0] expErrTag;

    always #5 clk = ~clk;

    mem_requester #(.MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_cmd_valid(cmdValid), .o_cmd_ready(cmdReady), .i_cmd_write(cmdWrite),
        .i_cmd_address(cmdAddress), .i_cmd_data(cmdData),
        .o_wr_en(wrEn), .o_wr_address(wrAddress), .o_wr_data(wrData),
        .o_rd_en(rdEn), .o_rd_address(rdAddress),
        .i_wr_ret_ack(wrRetAck), .i_wr_ret_address(wrRetAddress),
        .i_rd_ret_ack(rdRetAck), .i_rd_ret_address(rdRetAddress), .i_rd_ret_data(rdRetData),
        .o_rd_resp_valid(rdRespValid), .o_rd_resp_address(rdRespAddress), .o_rd_resp_data(rdRespData),
        .o_wr_resp_valid(wrRespValid), .o_wr_resp_address(wrRespAddress),
        .o_outstanding(outstanding), .o_err_unexpected(errUnexpected),
        .o_err_timeout(errTimeout), .o_err_tag(errTag)
    );

    function automatic int mdlFind(input logic [15:0] a);
        for (int i = 0; i < mdl.size(); i++) begin
            if (mdl[i].addr == a) return i;
        end
        return -1;
    endfunction

    task automatic clearModel();
        mdl.delete();
        expReady = 1'b1; expRdEn = 1'b0; expWrEn = 1'b0;
        expRdAddr = '0; expWrAddr = '0; expWrData = '0;
        expRdResp = 1'b0; expRdRespAddr = '0; expRdRespData = '0;
        expWrResp = 1'b0; expWrRespAddr = '0; expOut = '0;
        expErrUnexp = 1'b0; expErrTimeout = 1'b0; expErrTag = '0;
    endtask

    // Drive one cycle of inputs and advance the model to the state after the next edge
    task automatic applyStimulus(input logic v, input logic w, input logic [15:0] a, input logic [15:0] d,
                                 input logic ra, input logic [15:0] raddr, input logic [15:0] rdata,
                                 input logic wa, input logic [15:0] waddr);
        int   rk;
        int   wk;
        bit   rHit;
        bit   wHit;
        bit   accept;
        ent_t e;
        ent_t nq[$];
        cmdValid = v; cmdWrite = w; cmdAddress = a; cmdData = d;
        rdRetAck = ra; rdRetAddress = raddr; rdRetData = rdata;
        wrRetAck = wa; wrRetAddress = waddr;
        expReady = (mdl.size() < MAXO) && (mdlFind(a) < 0);
        accept   = v && expReady;
        expRdEn  = accept && !w;
        expWrEn  = accept && w;
        if (accept && w) begin expWrAddr = a; expWrData = d; end
        if (accept && !w) expRdAddr = a;
        rk = mdlFind(raddr);
        wk = mdlFind(waddr);
        rHit = 1'b0;
        wHit = 1'b0;
        if (ra && rk >= 0) rHit = !mdl[rk].isWrite;
        if (wa && wk >= 0) wHit = mdl[wk].isWrite;
        if ((ra && !rHit) || (wa && !wHit)) expErrUnexp = 1'b1;
        expRdResp = rHit;
        expWrResp = wHit;
        if (rHit) begin expRdRespAddr = raddr; expRdRespData = rdata; end
        if (wHit) expWrRespAddr = waddr;
        for (int i = 0; i < mdl.size(); i++) begin
            e = mdl[i];
            if (!((rHit && e.addr == raddr) || (wHit && e.addr == waddr))) begin
`ifdef MEM_REQUESTER_TIMEOUT_EN
                if (e.age == TO) begin
                    if (!expErrTimeout) expErrTag = e.addr;
                    expErrTimeout = 1'b1;
                end else begin
                    e.age = e.age + 1;
                    nq.push_back(e);
                end
`else
                nq.push_back(e);
`endif
            end
        end
        if (accept) begin
            e.addr = a; e.isWrite = w; e.age = 0;
            nq.push_back(e);
        end
        mdl = nq;
        expOut = 4'(mdl.size());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            tick();
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        clearModel();
        #2;
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 16'h00AA, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        idle(0);
        reset = 1'b1;
        cmdValid = 1'b0;
        #2;
        checks++; if (outstanding !== 4'd0) begin failures++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); end
        checks++; if (rdEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_en: got %0h expected 0", rdEn); end
        checks++; if (rdAddress !== 16'h0) begin failures++; $display("[TB] FAIL reset_rd_address: got %h expected 0000", rdAddress); end
        checks++; if (errUnexpected !== 1'b0 || errTimeout !== 1'b0 || errTag !== 16'h0) begin failures++; $display("[TB] FAIL reset_errors: got %0h/%0h/%h expected 0/0/0000", errUnexpected, errTimeout, errTag); end
        checks++; if (rdRespValid !== 1'b0 || wrRespValid !== 1'b0 || wrEn !== 1'b0) begin failures++; $display("[TB] FAIL reset_pulses: got %0h%0h%0h expected 000", rdRespValid, wrRespValid, wrEn); end
        doReset();
    endtask

    task automatic test_single_read();
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #1;
        checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL single_ready: got %0h expected 1", cmdReady); end
        tick();
        checks++; if (rdEn !== 1'b1 || rdAddress !== 16'h0010 || wrEn !== 1'b0) begin failures++; $display("[TB] FAIL single_rd_pulse: got en=%0h addr=%h wr=%0h expected 1/0010/0", rdEn, rdAddress, wrEn); end
        checks++; if (outstanding !== 4'd1) begin failures++; $display("[TB] FAIL single_out1: got %0d expected 1", outstanding); end
        idle(1);
        checks++; if (rdEn !== 1'b0) begin failures++; $display("[TB] FAIL single_rd_once: got %0h expected 0", rdEn); end
        idle(4);
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
        tick();
        checks++; if (rdRespValid !== 1'b1 || rdRespData !== 16'hBEEF || rdRespAddress !== 16'h0010) begin failures++; $display("[TB] FAIL single_resp: got v=%0h d=%h a=%h expected 1/beef/0010", rdRespValid, rdRespData, rdRespAddress); end
        checks++; if (outstanding !== 4'd0) begin failures++; $display("[TB] FAIL single_out0: got %0d expected 0", outstanding); end
        idle(1);
        checks++; if (rdRespValid !== 1'b0) begin failures++; $display("[TB] FAIL single_resp_once: got %0h expected 0", rdRespValid); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b0, 16'(i), 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            tick();
        end
        checks++; if (outstanding !== 4'd4) begin failures++; $display("[TB] FAIL full_out4: got %0d expected 4", outstanding); end
        applyStimulus(1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #1;
        checks++; if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_low: got %0h expected 0", cmdReady); end
        tick();
        checks++; if (rdEn !== 1'b0 || outstanding !== 4'd4) begin failures++; $display("[TB] FAIL full_blocked: got en=%0h out=%0d expected 0/4", rdEn, outstanding); end
        applyStimulus(1'b1, 1'b0, 16'h0005, 16'h0, 1'b1, 16'h0002, 16'h2222, 1'b0, 16'h0);
        #1;
        checks++; if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_same_edge: got %0h expected 0", cmdReady); end
        tick();
        checks++; if (outstanding !== 4'd3 || rdRespValid !== 1'b1) begin failures++; $display("[TB] FAIL full_free: got out=%0d resp=%0h expected 3/1", outstanding, rdRespValid); end
        applyStimulus(1'b1, 1'b0, 16'h0005, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #1;
        checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_again: got %0h expected 1", cmdReady); end
        tick();
        checks++; if (rdEn !== 1'b1 || rdAddress !== 16'h0005 || outstanding !== 4'd4) begin failures++; $display("[TB] FAIL full_reuse: got en=%0h a=%h out=%0d expected 1/0005/4", rdEn, rdAddress, outstanding); end
        foreach (mdl[i]) begin end
        for (int i = 1; i <= 5; i++) begin
            if (i != 2) begin
                applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'(i), 16'(i * 3), 1'b0, 16'h0);
                tick();
            end
        end
        checks++; if (outstanding !== 4'd0 || errUnexpected !== 1'b0) begin failures++; $display("[TB] FAIL full_drain: got out=%0d err=%0h expected 0/0", outstanding, errUnexpected); end
    endtask

    task automatic test_conflict();
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
            #1;
            checks++; if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL conflict_ready_%0d: got %0h expected 0", i, cmdReady); end
            tick();
        end
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1, 16'h0020, 16'h5555, 1'b0, 16'h0);
        #1;
        checks++; if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL conflict_ready_ret: got %0h expected 0", cmdReady); end
        tick();
        checks++; if (wrEn !== 1'b0 || outstanding !== 4'd0) begin failures++; $display("[TB] FAIL conflict_after_ret: got wr=%0h out=%0d expected 0/0", wrEn, outstanding); end
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'h1234, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #1;
        checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL conflict_ready_free: got %0h expected 1", cmdReady); end
        tick();
        checks++; if (wrEn !== 1'b1 || rdEn !== 1'b0 || wrAddress !== 16'h0020 || wrData !== 16'h1234) begin failures++; $display("[TB] FAIL conflict_wr_pulse: got en=%0h rd=%0h a=%h d=%h expected 1/0/0020/1234", wrEn, rdEn, wrAddress, wrData); end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0020);
        tick();
        checks++; if (wrRespValid !== 1'b1 || wrRespAddress !== 16'h0020 || outstanding !== 4'd0) begin failures++; $display("[TB] FAIL conflict_wr_resp: got v=%0h a=%h out=%0d expected 1/0020/0", wrRespValid, wrRespAddress, outstanding); end
    endtask

    task automatic test_unexpected();
        applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        checks++; if (errUnexpected !== 1'b0) begin failures++; $display("[TB] FAIL unexp_clear: got %0h expected 0", errUnexpected); end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h7777, 16'h9999, 1'b0, 16'h0);
        tick();
        checks++; if (errUnexpected !== 1'b1 || rdRespValid !== 1'b0 || outstanding !== 4'd1) begin failures++; $display("[TB] FAIL unexp_nomatch: got err=%0h resp=%0h out=%0d expected 1/0/1", errUnexpected, rdRespValid, outstanding); end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0040);
        tick();
        checks++; if (wrRespValid !== 1'b0 || outstanding !== 4'd1) begin failures++; $display("[TB] FAIL unexp_wrong_channel: got resp=%0h out=%0d expected 0/1", wrRespValid, outstanding); end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0040, 16'h0404, 1'b0, 16'h0);
        tick();
        checks++; if (rdRespValid !== 1'b1 || outstanding !== 4'd0 || errUnexpected !== 1'b1) begin failures++; $display("[TB] FAIL unexp_recover: got resp=%0h out=%0d err=%0h expected 1/0/1", rdRespValid, outstanding, errUnexpected); end
    endtask

    task automatic test_simultaneous();
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h0001, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 16'h0002, 16'hCAFE, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        checks++; if (outstanding !== 4'd2) begin failures++; $display("[TB] FAIL simul_out2: got %0d expected 2", outstanding); end
        applyStimulus(1'b1, 1'b0, 16'h0003, 16'h0, 1'b1, 16'h0001, 16'hA5A5, 1'b1, 16'h0002);
        tick();
        checks++; if (rdRespValid !== 1'b1 || wrRespValid !== 1'b1) begin failures++; $display("[TB] FAIL simul_both_resp: got rd=%0h wr=%0h expected 1/1", rdRespValid, wrRespValid); end
        checks++; if (rdRespData !== 16'hA5A5 || wrRespAddress !== 16'h0002) begin failures++; $display("[TB] FAIL simul_resp_fields: got d=%h a=%h expected a5a5/0002", rdRespData, wrRespAddress); end
        checks++; if (outstanding !== 4'd1 || rdEn !== 1'b1 || rdAddress !== 16'h0003) begin failures++; $display("[TB] FAIL simul_accept_free: got out=%0d en=%0h a=%h expected 1/1/0003", outstanding, rdEn, rdAddress); end
        checks++; if (errUnexpected !== 1'b0) begin failures++; $display("[TB] FAIL simul_no_err: got %0h expected 0", errUnexpected); end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0003, 16'h0333, 1'b0, 16'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 1'b0, 16'h0060, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0060, 16'h0, 1'b1, 16'h0060, 16'h6060, 1'b0, 16'h0);
        #1;
        checks++; if (cmdReady !== 1'b0) begin failures++; $display("[TB] FAIL b2b_ready_ret_edge: got %0h expected 0", cmdReady); end
        tick();
        applyStimulus(1'b1, 1'b0, 16'h0060, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        #1;
        checks++; if (cmdReady !== 1'b1) begin failures++; $display("[TB] FAIL b2b_ready_next: got %0h expected 1", cmdReady); end
        tick();
        checks++; if (rdEn !== 1'b1 || outstanding !== 4'd1) begin failures++; $display("[TB] FAIL b2b_reissue: got en=%0h out=%0d expected 1/1", rdEn, outstanding); end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0060, 16'h0606, 1'b0, 16'h0);
        tick();
    endtask

    task automatic test_reset_midflight();
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h0050, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        checks++; if (outstanding !== 4'd1) begin failures++; $display("[TB] FAIL midflight_out1: got %0d expected 1", outstanding); end
        doReset();
        checks++; if (outstanding !== 4'd0) begin failures++; $display("[TB] FAIL midflight_discard: got %0d expected 0", outstanding); end
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0050, 16'h5050, 1'b0, 16'h0);
        tick();
        checks++; if (errUnexpected !== 1'b1 || rdRespValid !== 1'b0) begin failures++; $display("[TB] FAIL midflight_late_ret: got err=%0h resp=%0h expected 1/0", errUnexpected, rdRespValid); end
    endtask

`ifdef MEM_REQUESTER_TIMEOUT_EN
    task automatic test_timeout();
        doReset();
        applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        tick();
        idle(TO);
        checks++; if (outstanding !== 4'd1 || errTimeout !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early: got out=%0d err=%0h expected 1/0", outstanding, errTimeout); end
        idle(1);
        checks++; if (errTimeout !== 1'b1 || errTag !== 16'h0030 || outstanding !== 4'd0) begin failures++; $display("[TB] FAIL timeout_fire: got err=%0h tag=%h out=%0d expected 1/0030/0", errTimeout, errTag, outstanding); end
        checks++; if (rdRespValid !== 1'b0) begin failures++; $display("[TB] FAIL timeout_no_resp: got %0h expected 0", rdRespValid); end
    endtask
`endif

    task automatic test_random();
        logic        v;
        logic        w;
        logic [15:0] a;
        logic        ra;
        logic        wa;
        logic [15:0] raddr;
        logic [15:0] waddr;
        doReset();
        for (int c = 0; c < 400; c++) begin
            v = ($urandom_range(0, 3) != 0);
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 7));
            ra = ($urandom_range(0, 2) == 0);
            wa = ($urandom_range(0, 2) == 0);
            if (mdl.size() > 0 && $urandom_range(0, 3) != 0) raddr = mdl[$urandom_range(0, mdl.size() - 1)].addr;
            else raddr = 16'($urandom_range(0, 9));
            if (mdl.size() > 0 && $urandom_range(0, 3) != 0) waddr = mdl[$urandom_range(0, mdl.size() - 1)].addr;
            else waddr = 16'($urandom_range(0, 9));
            applyStimulus(v, w, a, 16'($urandom), ra, raddr, 16'($urandom), wa, waddr);
            #1;
            checks++; if (cmdReady !== expReady) begin failures++; $display("[TB] FAIL rand_ready c=%0d: got %0h expected %0h", c, cmdReady, expReady); end
            tick();
            checks++; if (rdEn !== expRdEn || wrEn !== expWrEn) begin failures++; $display("[TB] FAIL rand_en c=%0d: got rd=%0h wr=%0h expected %0h/%0h", c, rdEn, wrEn, expRdEn, expWrEn); end
            checks++; if (rdAddress !== expRdAddr || wrAddress !== expWrAddr || wrData !== expWrData) begin failures++; $display("[TB] FAIL rand_fields c=%0d: got %h/%h/%h expected %h/%h/%h", c, rdAddress, wrAddress, wrData, expRdAddr, expWrAddr, expWrData); end
            checks++; if (rdRespValid !== expRdResp || wrRespValid !== expWrResp) begin failures++; $display("[TB] FAIL rand_resp_valid c=%0d: got %0h/%0h expected %0h/%0h", c, rdRespValid, wrRespValid, expRdResp, expWrResp); end
            if (expRdResp) begin
                checks++; if (rdRespAddress !== expRdRespAddr || rdRespData !== expRdRespData) begin failures++; $display("[TB] FAIL rand_rd_resp c=%0d: got %h/%h expected %h/%h", c, rdRespAddress, rdRespData, expRdRespAddr, expRdRespData); end
            end
            if (expWrResp) begin
                checks++; if (wrRespAddress !== expWrRespAddr) begin failures++; $display("[TB] FAIL rand_wr_resp c=%0d: got %h expected %h", c, wrRespAddress, expWrRespAddr); end
            end
            checks++; if (outstanding !== expOut) begin failures++; $display("[TB] FAIL rand_outstanding c=%0d: got %0d expected %0d", c, outstanding, expOut); end
            checks++; if (errUnexpected !== expErrUnexp) begin failures++; $display("[TB] FAIL rand_err_unexp c=%0d: got %0h expected %0h", c, errUnexpected, expErrUnexp); end
            checks++; if (errTimeout !== expErrTimeout || errTag !== expErrTag) begin failures++; $display("[TB] FAIL rand_err_timeout c=%0d: got %0h/%h expected %0h/%h", c, errTimeout, errTag, expErrTimeout, expErrTag); end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
        clearModel();
        #12;
        @(negedge clk);
        reset = 1'b0;
        tick();
        $display("[TB] starting directed scenarios");
        test_reset();
        test_single_read();
        test_full();
        test_conflict();
        test_unexpected();
        test_simultaneous();
        test_back_to_back();
        test_reset_midflight();
`ifdef MEM_REQUESTER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] starting randomized run");
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_requester.md
# mem_requester

Initiator-side client of the memory controller's write/read request interface. Accepts simple commands from a test or CPU-side source, drives `wr_en`/`rd_en` request pulses toward the controller, and tracks up to `MAX_OUTSTANDING` in-flight requests in a tag table (tag = address). Matches `rd_ret_*` and `wr_ret_*` acknowledgements back to table entries, delivers responses to the client, and flags protocol errors.

## Interface
- `MAX_OUTSTANDING`, 4: tracking-table depth (1–8).
- `TIMEOUT`, 255: cycles an entry may stay outstanding before being dropped (only with timeout macro).
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  client command present.
- `cmd_ready`  out  1  command accepted on this edge when `cmd_valid` is also high.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_address`  in  16  request address / tag.
- `cmd_data`  in  16  write data.
- `wr_en`, `rd_en`  out  1  one-cycle request pulses to the controller.
- `wr_address`, `wr_data`, `rd_address`  out  16  request fields, valid with the pulse.
- `wr_ret_ack`, `rd_ret_ack`  in  1  controller return strobes.
- `wr_ret_address`, `rd_ret_address`  in  16  returned tags.
- `rd_ret_data`  in  16  returned read data.
- `rd_resp_valid`  out  1  one-cycle read-completion pulse; `rd_resp_address`/`rd_resp_data` out 16.
- `wr_resp_valid`  out  1  one-cycle write-completion pulse; `wr_resp_address` out 16.
- `outstanding`  out  4  number of valid table entries.
- `err_unexpected`  out  1  sticky: return with no matching entry.
- `err_timeout`  out  1  sticky: entry aged out; `err_tag` out 16 holds first timed-out address.

## Operation
- Table entry: valid, address[15:0], is_write, age counter.
- `cmd_ready` = !full && !conflict; conflict = any valid entry with address == `cmd_address` (tags must be unique). Combinational from registered state only.
- Accept (`cmd_valid && cmd_ready`): allocate lowest-index free entry, age = 0; register request fields, pulse `wr_en` or `rd_en` the next cycle. Never both pulses in one cycle.
- Read return: `rd_ret_ack` with address matching a valid read entry → free entry, register `rd_resp_*`. Write return: likewise with write entries → `wr_resp_*`. Read and write returns in the same cycle are both processed.
- Return matching a write entry on the read channel (or vice versa), or matching nothing → ignored, `err_unexpected` set.
- Same-cycle accept and free: allocation and conflict check use pre-edge state; a slot freed this edge is reusable next cycle. `outstanding` = old + accepts − frees.
- Idle outputs: request fields hold last value; enables low.

## Timing
- Reset: all outputs 0, table cleared, sticky errors cleared; asynchronous assertion, synchronous-safe release.
- Command accepted at edge N → `rd_en`/`wr_en` high during cycle N+1 only.
- Return strobe sampled at edge M → `*_resp_valid` high during cycle M+1; `outstanding` reflects free after edge M.
- Minimum turnaround: a read can be re-issued to the same address in the cycle after its return is sampled.
- Reset mid-flight: in-flight entries discarded; later returns for them raise `err_unexpected`.

## Configuration
- `MEM_REQUESTER_TIMEOUT_EN` defined: age increments each cycle per valid entry (saturating); when age == `TIMEOUT`, entry freed without response, `err_timeout` set, `err_tag` captured if not already set.
- Undefined: no age counters, entries wait indefinitely, `err_timeout` and `err_tag` tied 0.

## Test plan
- Read 0x0010 accepted, return 0x0010/0xBEEF after 5 cycles → `rd_en` one pulse next cycle, `rd_resp_data`=0xBEEF one cycle after return, `outstanding` 1→0.
- Issue 4 reads 0x0001–0x0004 with no returns → `cmd_ready` low on 5th, `outstanding`=4; return 0x0002 → ready next cycle, new command takes freed slot.
- Read 0x0020 outstanding, new write 0x0020 presented → `cmd_ready`=0 until read return sampled.
- `rd_ret_ack` with 0x7777 (no entry) → `err_unexpected`=1, no `rd_resp_valid`, table unchanged.
- Simultaneous `rd_ret_ack` 0x0001 and `wr_ret_ack` 0x0002 → both resp pulses same cycle, `outstanding` drops by 2.
- Timeout enabled, `TIMEOUT`=8, read 0x0030 never returned → `err_timeout`=1, `err_tag`=0x0030, `outstanding`=0.
